// File: rtl/usb_token_rx.sv
// Receive-side USB token decoder: parses OUT/IN/SETUP tokens, checks the PID nibble and CRC5.
// Define USB_TOKEN_SOF_EN to also accept SOF tokens and report the frame number.
module usb_token_rx #(
   parameter bit ADDR_MATCH = 1'b1,
   parameter bit NONTOK_ERR = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_active,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic [6:0]  dev_addr,
   output logic        tok_valid,
   output logic        tok_err,
   output logic [1:0]  err_code,
   output logic [3:0]  tok_pid,
   output logic [6:0]  tok_addr,
   output logic [3:0]  tok_endp,
   output logic [10:0] frame_num
);

   typedef enum logic [2:0] {
      S_IDLE, S_PID, S_TOK1, S_TOK2, S_WAIT_EOP, S_DISCARD
   } state_t;

   localparam logic [1:0] ERR_PID    = 2'd0;
   localparam logic [1:0] ERR_CRC    = 2'd1;
   localparam logic [1:0] ERR_LEN    = 2'd2;
   localparam logic [1:0] ERR_NONTOK = 2'd3;

   state_t      r_state, w_next;
   logic        r_fresh;
   logic [3:0]  r_pid;
   logic [7:0]  r_b1, r_b2;
   logic [4:0]  r_crc;
   logic        r_pend;
   logic [1:0]  r_pend_code;

   logic        w_byte, w_eop, w_pid_ok, w_is_tok, w_is_sof, w_crc_ok, w_addr_ok;
   logic        w_set_pend, w_fire_valid, w_fire_err;
   logic [1:0]  w_pend_code, w_fire_code;

   // Serial CRC5 steps unrolled over the low nbits of d, LSB first.
   function automatic logic [4:0] crc5_upd(input logic [4:0] c_in, input logic [7:0] d,
                                           input int nbits);
      logic [4:0] c;
      logic       fb;
      // NOTE: blocking assignments are right here: c/fb are temporaries evaluated in order.
      c = c_in;
      for (int i = 0; i < 8; i++) begin
         if (i < nbits) begin
            fb = c[4] ^ d[i];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
         end
      end
      return c;
   endfunction

   assign w_byte   = rx_active & rx_valid;
   assign w_eop    = ~rx_active;
   assign w_pid_ok = (rx_data[7:4] == ~rx_data[3:0]);

   always_comb begin
      case (rx_data[3:0])
         4'h1, 4'h9, 4'hD: w_is_tok = 1'b1;
`ifdef USB_TOKEN_SOF_EN
         4'h5:             w_is_tok = 1'b1;
`endif
         default:          w_is_tok = 1'b0;
      endcase
   end

`ifdef USB_TOKEN_SOF_EN
   assign w_is_sof = (r_pid == 4'h5);
`else
   assign w_is_sof = 1'b0;
`endif

   // The received CRC field is the inverted remainder, bit 4 in b2[7].
   assign w_crc_ok  = (r_b2[7:3] == ~r_crc);
   assign w_addr_ok = !ADDR_MATCH || w_is_sof || (r_b1[6:0] == dev_addr);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      w_next       = r_state;
      w_set_pend   = 1'b0;
      w_pend_code  = ERR_PID;
      w_fire_valid = 1'b0;
      w_fire_err   = 1'b0;
      w_fire_code  = ERR_PID;
      case (r_state)
         S_IDLE: begin
            if (rx_active) w_next = r_fresh ? S_DISCARD : S_PID;
         end
         S_PID: begin
            if (w_eop) begin
               w_fire_err  = 1'b1;
               w_fire_code = ERR_LEN;
               w_next      = S_IDLE;
            end else if (rx_valid) begin
               if (!w_pid_ok) begin
                  w_set_pend  = 1'b1;
                  w_pend_code = ERR_PID;
                  w_next      = S_DISCARD;
               end else if (w_is_tok) begin
                  w_next = S_TOK1;
               end else begin
                  w_set_pend  = NONTOK_ERR;
                  w_pend_code = ERR_NONTOK;
                  w_next      = S_DISCARD;
               end
            end
         end
         S_TOK1, S_TOK2: begin
            if (w_eop) begin
               w_fire_err  = 1'b1;
               w_fire_code = ERR_LEN;
               w_next      = S_IDLE;
            end else if (rx_valid) begin
               w_next = (r_state == S_TOK1) ? S_TOK2 : S_WAIT_EOP;
            end
         end
         S_WAIT_EOP: begin
            if (w_eop) begin
               w_fire_err   = !w_crc_ok;
               w_fire_code  = ERR_CRC;
               w_fire_valid = w_crc_ok && w_addr_ok;
               w_next       = S_IDLE;
            end else if (rx_valid) begin
               w_set_pend  = 1'b1;
               w_pend_code = ERR_LEN;
               w_next      = S_DISCARD;
            end
         end
         S_DISCARD: begin
            if (w_eop) begin
               w_fire_err  = r_pend;
               w_fire_code = r_pend_code;
               w_next      = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fresh     <= 1'b1;
         r_pid       <= '0;
         r_b1        <= '0;
         r_b2        <= '0;
         r_crc       <= 5'b11111;
         r_pend      <= 1'b0;
         r_pend_code <= '0;
         tok_valid   <= 1'b0;
         tok_err     <= 1'b0;
         err_code    <= '0;
         tok_pid     <= '0;
         tok_addr    <= '0;
         tok_endp    <= '0;
      end else begin
         r_fresh   <= 1'b0;
         tok_valid <= w_fire_valid;
         tok_err   <= w_fire_err;
         if (w_fire_err) err_code <= w_fire_code;
         if (r_state == S_IDLE) begin
            r_crc  <= 5'b11111;
            r_pend <= 1'b0;
         end
         if (r_state == S_PID && w_byte) r_pid <= rx_data[3:0];
         if (r_state == S_TOK1 && w_byte) begin
            r_b1  <= rx_data;
            r_crc <= crc5_upd(r_crc, rx_data, 8);
         end
         if (r_state == S_TOK2 && w_byte) begin
            r_b2  <= rx_data;
            r_crc <= crc5_upd(r_crc, rx_data, 3);
         end
         if (w_set_pend) begin
            r_pend      <= 1'b1;
            r_pend_code <= w_pend_code;
         end
         if (w_fire_valid) begin
            tok_pid <= r_pid;
            if (!w_is_sof) begin
               tok_addr <= r_b1[6:0];
               tok_endp <= {r_b2[2:0], r_b1[7]};
            end
         end
      end
   end

`ifdef USB_TOKEN_SOF_EN
   always_ff @(posedge clk) begin
      if (rst)                          frame_num <= '0;
      else if (w_fire_valid && w_is_sof) frame_num <= {r_b2[2:0], r_b1};
   end
`else
   assign frame_num = '0;
`endif

endmodule

// File: tb/tb_usb_token_rx.sv
// Directed bench for usb_token_rx: default instance plus one with ADDR_MATCH=0, NONTOK_ERR=1.
`timescale 1ns/1ps
module tb_usb_token_rx;

   logic        clk = 1'b0;
   logic        rst, rx_active, rx_valid;
   logic [7:0]  rx_data;
   logic [6:0]  dev_addr;

   logic        d_valid, d_err, n_valid, n_err;
   logic [1:0]  d_code, n_code;
   logic [3:0]  d_pid, d_endp, n_pid, n_endp;
   logic [6:0]  d_addr, n_addr;
   logic [10:0] d_frame, n_frame;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   usb_token_rx u_dut (
      .clk(clk), .rst(rst), .rx_active(rx_active), .rx_valid(rx_valid),
      .rx_data(rx_data), .dev_addr(dev_addr),
      .tok_valid(d_valid), .tok_err(d_err), .err_code(d_code), .tok_pid(d_pid),
      .tok_addr(d_addr), .tok_endp(d_endp), .frame_num(d_frame)
   );

   usb_token_rx #(.ADDR_MATCH(1'b0), .NONTOK_ERR(1'b1)) u_dut_nt (
      .clk(clk), .rst(rst), .rx_active(rx_active), .rx_valid(rx_valid),
      .rx_data(rx_data), .dev_addr(dev_addr),
      .tok_valid(n_valid), .tok_err(n_err), .err_code(n_code), .tok_pid(n_pid),
      .tok_addr(n_addr), .tok_endp(n_endp), .frame_num(n_frame)
   );

   // Inverted CRC5 remainder over b1 and the 3 low bits of b2, as carried in b2[7:3].
   function automatic logic [4:0] crc_field(input logic [7:0] b1, input logic [2:0] b2lo);
      logic [10:0] bits;
      logic [4:0]  c;
      logic        fb;
      bits = {b2lo, b1};
      c    = 5'b11111;
      for (int i = 0; i < 11; i++) begin
         fb = c[4] ^ bits[i];
         c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
      end
      return ~c;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Lead cycle with rx_active high, n bytes, then EOP; returns in the strobe cycle.
   task automatic send_pkt(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
      logic [7:0] bytes [5];
      bytes = '{b0, b1, b2, b3, b4};
      rx_active = 1'b1;
      rx_valid  = 1'b0;
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         rx_valid = 1'b1;
         rx_data  = bytes[i];
         @(negedge clk);
      end
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      rx_active = 1'b0;
      @(negedge clk);
   endtask

   task automatic chk_strobe(input string tag, input logic dv, input logic de,
                             input logic [1:0] dc, input logic nv, input logic ne,
                             input logic [1:0] nc);
      check({tag, ".d.valid"}, d_valid, dv);
      check({tag, ".d.err"},   d_err,   de);
      if (de) check({tag, ".d.code"}, d_code, dc);
      check({tag, ".n.valid"}, n_valid, nv);
      check({tag, ".n.err"},   n_err,   ne);
      if (ne) check({tag, ".n.code"}, n_code, nc);
   endtask

   logic [7:0] b2_16, b2_sof;

   initial begin
      rst = 1'b1; rx_active = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; dev_addr = 7'h15;
      repeat (3) @(negedge clk);
      check("rst.valid", d_valid, 1'b0);
      check("rst.err",   d_err,   1'b0);
      check("rst.code",  d_code,  2'd0);
      check("rst.pid",   d_pid,   4'h0);
      check("rst.addr",  d_addr,  7'h00);
      check("rst.endp",  d_endp,  4'h0);
      check("rst.frame", d_frame, 11'h000);
      rst = 1'b0;
      @(negedge clk);

      // Good OUT token, addr 0x15 endp 0xE
      send_pkt(3, 8'hE1, 8'h15, 8'hBF, 8'h00, 8'h00);
      chk_strobe("out_ok", 1, 0, 0, 1, 0, 0);
      check("out_ok.pid",  d_pid,  4'h1);
      check("out_ok.addr", d_addr, 7'h15);
      check("out_ok.endp", d_endp, 4'hE);
      @(negedge clk);
      check("out_ok.one_cycle", d_valid, 1'b0);

      // CRC failure: outputs hold
      send_pkt(3, 8'hE1, 8'h15, 8'hBE, 8'h00, 8'h00);
      chk_strobe("crc_bad", 0, 1, 1, 0, 1, 1);
      check("crc_bad.addr_hold", d_addr, 7'h15);
      check("crc_bad.endp_hold", d_endp, 4'hE);

      // PID check failure, then short IN token
      send_pkt(3, 8'hE2, 8'h15, 8'hBF, 8'h00, 8'h00);
      chk_strobe("pid_bad", 0, 1, 0, 0, 1, 0);
      send_pkt(2, 8'h69, 8'h15, 8'h00, 8'h00, 8'h00);
      chk_strobe("short2", 0, 1, 2, 0, 1, 2);
      send_pkt(0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      chk_strobe("empty", 0, 1, 2, 0, 1, 2);
      send_pkt(1, 8'hE2, 8'h00, 8'h00, 8'h00, 8'h00);
      chk_strobe("pid_over_len", 0, 1, 0, 0, 1, 0);

      // Long token, then DATA0 packet
      send_pkt(4, 8'hE1, 8'h15, 8'hBF, 8'h00, 8'h00);
      chk_strobe("long", 0, 1, 2, 0, 1, 2);
      send_pkt(5, 8'hC3, 8'h11, 8'h22, 8'h33, 8'h44);
      chk_strobe("data0", 0, 0, 0, 0, 1, 3);

      // Address mismatch on IN token to 0x16 endp 0
      b2_16 = {crc_field(8'h16, 3'b000), 3'b000};
      send_pkt(3, 8'h69, 8'h16, b2_16, 8'h00, 8'h00);
      chk_strobe("mismatch", 0, 0, 0, 1, 0, 0);
      check("mismatch.d_addr_hold", d_addr, 7'h15);
      check("mismatch.n_addr",      n_addr, 7'h16);
      check("mismatch.n_pid",       n_pid,  4'h9);

      // Back-to-back: next packet starts in the strobe cycle
      send_pkt(3, 8'h2D, 8'h15, 8'hBF, 8'h00, 8'h00);
      chk_strobe("setup", 1, 0, 0, 1, 0, 0);
      check("setup.pid", d_pid, 4'hD);
      send_pkt(3, 8'h69, 8'h15, 8'hBF, 8'h00, 8'h00);
      chk_strobe("b2b_in", 1, 0, 0, 1, 0, 0);
      check("b2b_in.pid", d_pid, 4'h9);

      // Reset mid-packet with rx_active held high
      rx_active = 1'b1; rx_valid = 1'b0;
      @(negedge clk);
      rx_valid = 1'b1; rx_data = 8'hE1;
      @(negedge clk);
      rx_data = 8'h15;
      @(negedge clk);
      rx_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst.pid",  d_pid,  4'h0);
      check("midrst.addr", d_addr, 7'h00);
      rx_valid = 1'b1; rx_data = 8'hBF;
      @(negedge clk);
      rx_valid = 1'b0; rx_active = 1'b0;
      @(negedge clk);
      chk_strobe("midrst.eop", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      send_pkt(3, 8'hE1, 8'h15, 8'hBF, 8'h00, 8'h00);
      chk_strobe("after_rst", 1, 0, 0, 1, 0, 0);
      check("after_rst.addr", d_addr, 7'h15);

      // SOF, frame 0x3A5
      b2_sof = {crc_field(8'hA5, 3'b011), 3'b011};
      send_pkt(3, 8'hA5, 8'hA5, b2_sof, 8'h00, 8'h00);
`ifdef USB_TOKEN_SOF_EN
      chk_strobe("sof", 1, 0, 0, 1, 0, 0);
      check("sof.frame",     d_frame, 11'h3A5);
      check("sof.pid",       d_pid,   4'h5);
      check("sof.addr_hold", d_addr,  7'h15);
`else
      chk_strobe("sof", 0, 0, 0, 0, 1, 3);
      check("sof.frame", d_frame, 11'h000);
`endif
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
